// File: rtl/stopwatch_pkg.sv
// Shared types for the stopwatch controller: command codes, FSM states and
// the default timer width.
package stopwatch_pkg;

    localparam int TIMER_W_DEFAULT = 4;

    typedef enum logic [1:0] {
        CMD_START = 2'd0,
        CMD_STOP  = 2'd1,
        CMD_CLEAR = 2'd2,
        CMD_LAP   = 2'd3
    } cmd_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PULSE,
        ST_SETTLE
    } state_e;

endpackage

// File: rtl/lap_fifo.sv
// Lap-time FIFO: circular buffer with occupancy counter, synchronous flush,
// and push-while-full accepted only when a pop frees a slot in the same cycle.
module lap_fifo #(
    parameter int TIMER_W   = 4,
    parameter int LAP_DEPTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               push,
    input  logic               pop,
    input  logic               flush,
    input  logic [TIMER_W-1:0] push_data,
    output logic               full,
    output logic               empty,
    output logic [TIMER_W-1:0] data
);

    localparam int PTR_W = $clog2(LAP_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [TIMER_W-1:0] mem [LAP_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic               do_push;
    logic               do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(LAP_DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Pointers are log2(depth) wide, so the increment wraps for free.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is deliberately left out of reset; validity comes from
    // count, and the output mux below forces zero while empty.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= push_data;
    end

    assign data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/stopwatch_ctrl.sv
// Command front-end for an external stopwatch: issues registered toggle/clear
// pulses with a fixed 3-cycle command period and buffers lap times.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int TIMER_W   = TIMER_W_DEFAULT,
    parameter int LAP_DEPTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cmd_valid,
    input  logic [1:0]         cmd,
    output logic               cmd_ready,
    output logic               sw_toggle,
    output logic               sw_reset,
    input  logic [TIMER_W-1:0] sw_timer,
    output logic               running,
    output logic               lap_valid,
    input  logic               lap_ready,
    output logic [TIMER_W-1:0] lap_data,
    output logic               lap_overflow
);

    state_e state_q;
    state_e state_d;
    cmd_e   cmd_code;
    logic   toggle_d;
    logic   clear_d;
    logic   lap_push;
    logic   lap_pop;
    logic   fifo_flush;
    logic   fifo_full;
    logic   fifo_empty;

    assign cmd_code  = cmd_e'(cmd);
    assign cmd_ready = (state_q == ST_IDLE);
    assign lap_valid = !fifo_empty;
    assign lap_pop   = lap_valid && lap_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // NOTE: every combinational output gets a default first so no path
    // through the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        toggle_d   = 1'b0;
        clear_d    = 1'b0;
        lap_push   = 1'b0;
        fifo_flush = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    case (cmd_code)
                        CMD_START: if (!running) begin
                            state_d  = ST_PULSE;
                            toggle_d = 1'b1;
                        end
                        CMD_STOP: if (running) begin
                            state_d  = ST_PULSE;
                            toggle_d = 1'b1;
                        end
                        CMD_CLEAR: begin
                            state_d    = ST_PULSE;
                            clear_d    = 1'b1;
                            fifo_flush = 1'b1;
                        end
                        CMD_LAP: lap_push = 1'b1;
                        default: state_d = ST_IDLE;
                    endcase
                end
            end
            ST_PULSE:  state_d = ST_SETTLE;
            ST_SETTLE: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // NOTE: registered state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sw_toggle    <= 1'b0;
            sw_reset     <= 1'b0;
            running      <= 1'b0;
            lap_overflow <= 1'b0;
        end else begin
            sw_toggle <= toggle_d;
            sw_reset  <= clear_d;
            // The mirror flips as the toggle pulse ends (PULSE -> SETTLE).
            if (state_q == ST_PULSE && sw_toggle) running <= ~running;
            if (fifo_flush)
                lap_overflow <= 1'b0;
            else if (lap_push && fifo_full && !lap_pop)
                lap_overflow <= 1'b1;
        end
    end

    lap_fifo #(
        .TIMER_W   (TIMER_W),
        .LAP_DEPTH (LAP_DEPTH)
    ) u_lap_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (lap_push),
        .pop       (lap_pop),
        .flush     (fifo_flush),
        .push_data (sw_timer),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .data      (lap_data)
    );

endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 Parameter TIMER_W, default 4, width of the stopwatch timer value.
REQ-002 Parameter LAP_DEPTH, default 4, lap FIFO entries (power of two, >=2).
REQ-003 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-004 clk  in  1  single clock; all logic on posedge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 cmd_valid  in  1  command present.
REQ-007 cmd  in  2  command code: 0 START, 1 STOP, 2 CLEAR, 3 LAP.
REQ-008 cmd_ready  out  1  controller can accept a command this cycle.
REQ-009 sw_toggle  out  1  one-cycle toggle pulse to the stopwatch.
REQ-010 sw_reset  out  1  one-cycle clear pulse to the stopwatch.
REQ-011 sw_timer  in  TIMER_W  current stopwatch count.
REQ-012 running  out  1  mirrored stopwatch on-state.
REQ-013 lap_valid  out  1  lap FIFO head valid.
REQ-014 lap_ready  in  1  consumer accepts the head.
REQ-015 lap_data  out  TIMER_W  lap FIFO head value.
REQ-016 lap_overflow  out  1  sticky; a lap was dropped.

Function
REQ-017 A command SHALL be accepted on a posedge where cmd_valid and cmd_ready are both high; cmd SHALL be held stable while cmd_valid is high and cmd_ready is low.
REQ-018 FSM states: IDLE (cmd_ready=1), PULSE (drive pulse, cmd_ready=0), SETTLE (cmd_ready=0); PULSE->SETTLE->IDLE unconditionally.
REQ-019 START accepted while running=0, or STOP accepted while running=1: IDLE->PULSE; sw_toggle=1 for exactly the PULSE cycle (cycle after acceptance); running SHALL invert on the PULSE->SETTLE edge.
REQ-020 START while running=1, or STOP while running=0: no-op; no pulse; FSM stays in IDLE; cmd_ready remains 1.
REQ-021 CLEAR: IDLE->PULSE; sw_reset=1 for exactly the PULSE cycle; running unchanged; lap FIFO flushed and lap_overflow cleared on the acceptance edge.
REQ-022 LAP: sw_timer sampled on the acceptance edge and pushed; FSM stays in IDLE; no pulse.
REQ-023 sw_toggle and sw_reset SHALL never be high in the same cycle, and each SHALL be registered (glitch-free).
REQ-024 Command latency: acceptance at edge N -> pulse high in cycle N..N+1 -> cmd_ready high again after edge N+2 (3-cycle command period).
REQ-025 lap_valid SHALL rise the cycle after a push into an empty FIFO; lap_data SHALL be the oldest entry; pop occurs when lap_valid and lap_ready are high.
REQ-026 LAP while FIFO full and no pop in the same cycle: value dropped, lap_overflow set; FIFO contents unchanged.
REQ-027 LAP while FIFO full with a simultaneous pop: push and pop both take effect; no overflow.
REQ-028 FIFO pointers SHALL wrap modulo LAP_DEPTH; occupancy counter width clog2(LAP_DEPTH)+1.
REQ-029 lap_data SHALL hold its value while lap_valid=1 and lap_ready=0.

Reset
REQ-030 On reset assertion, immediately: FSM=IDLE, cmd_ready=1, sw_toggle=0, sw_reset=0, running=0, FIFO empty (lap_valid=0), lap_data=0, lap_overflow=0.
REQ-031 Reset during PULSE or SETTLE SHALL abort the pulse in the same cycle; no further pulse after deassertion.
REQ-032 First command SHALL be accepted on the first posedge after reset deassertion.

Structure
REQ-033 Package stopwatch_pkg SHALL hold the command enum (CMD_START, CMD_STOP, CMD_CLEAR, CMD_LAP), the FSM state enum and the TIMER_W default.
REQ-034 The lap FIFO SHALL be a sub-module lap_fifo (push, pop, flush, full, empty, data), parameterized by TIMER_W and LAP_DEPTH.

Verification
REQ-035 Reset, START -> sw_toggle high one cycle after acceptance, running=1, cmd_ready low 2 cycles then high; START again -> no pulse, cmd_ready stays 1.
REQ-036 STOP while running=1 -> single sw_toggle pulse, running=0; STOP again -> no pulse.
REQ-037 sw_timer=4'h5, LAP -> lap_valid next cycle, lap_data=5; lap_ready=1 -> lap_valid=0.
REQ-038 lap_ready=0, 5 LAPs with sw_timer 1..5 -> FIFO holds 1..4, lap_overflow=1; CLEAR -> sw_reset pulse, lap_valid=0, lap_overflow=0, running unchanged.
REQ-039 FIFO full, LAP with lap_ready=1 same cycle -> head 1 popped, 5 pushed, no overflow; drain yields 2,3,4,5.
REQ-040 Reset asserted during PULSE of START -> sw_toggle drops immediately, running=0, cmd_ready=1; assertion checks sw_toggle && sw_reset never true.
